// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// One Wishbone master/slave link, used for both master-side ports of the
// arbiter and its single port towards wb_intercon.
//
// Signals (named from the bus master's point of view):
//   adr, dat_w, sel, we, cyc, stb : driven by the bus master
//   dat_r, ack, err               : driven by the bus slave
//
// Modports:
//   master : the side that issues cycles
//   slave  : the side that answers them
// -----------------------------------------------------------------------------
interface wb_arbiter_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32,
    parameter int SEL_W = 2
);
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [DAT_W-1:0] dat_r;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
    logic             ack;
    logic             err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Two-master to one-slave Wishbone arbiter. Master 0 is the moxie core,
// master 1 a secondary bus master (DMA / debug). Round-robin between them;
// the owner keeps the bus for as long as it holds cyc, and there is exactly
// one idle cycle between owners.
//
// Ports:
//   clk_i  : system clock
//   rst_i  : asynchronous, active-high reset
//   m0     : link to master 0 (slave modport: arbiter answers it)
//   m1     : link to master 1
//   s      : link to wb_intercon (master modport: arbiter drives it);
//            s.err is not used
//   gnt_o  : one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
//
// Optional build macro WB_ARBITER_TIMEOUT_EN: a strobe stalled for TIMEOUT
// cycles is terminated with a one-cycle err to the owner. Without it err is
// tied low and a stalled slave holds the owner indefinitely.
//
// state | meaning
// IDLE  | nobody owns the bus, slave side quiet
// OWN0  | master 0 owns the bus
// OWN1  | master 1 owns the bus
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_arbiter_if.slave  m0,
    wb_arbiter_if.slave  m1,
    wb_arbiter_if.master s,
    output logic [1:0]   gnt_o
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT must lie in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t r_state;
    logic   r_last;

    logic             w_own0;
    logic             w_own1;
    logic             w_own;
    logic             w_cyc;
    logic             w_stb_req;
    logic             w_stb;
    logic             w_ack;
    logic             w_timeout;
    logic             w_we;
    logic [ADR_W-1:0] w_adr;
    logic [DAT_W-1:0] w_dat;
    logic [SEL_W-1:0] w_sel;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);
    assign w_own  = w_own0 | w_own1;

    // Owner's request path to the slave; everything zero while idle.
    always_comb begin
        w_cyc     = 1'b0;
        w_stb_req = 1'b0;
        w_we      = 1'b0;
        w_adr     = '0;
        w_dat     = '0;
        w_sel     = '0;
        if (w_own0) begin
            w_cyc     = m0.cyc;
            w_stb_req = m0.stb;
            w_we      = m0.we;
            w_adr     = m0.adr;
            w_dat     = m0.dat_w;
            w_sel     = m0.sel;
        end else if (w_own1) begin
            w_cyc     = m1.cyc;
            w_stb_req = m1.stb;
            w_we      = m1.we;
            w_adr     = m1.adr;
            w_dat     = m1.dat_w;
            w_sel     = m1.sel;
        end
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_tcnt;

    assign w_timeout = w_own & w_stb_req & ~s.ack & (r_tcnt == TC_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // The err cycle withdraws the strobe, which also gates off any ack
    // arriving in that cycle; an ack without our strobe is never forwarded.
    assign w_stb = w_stb_req & ~w_timeout;
    assign w_ack = w_stb & s.ack;

    assign s.cyc   = w_cyc;
    assign s.stb   = w_stb;
    assign s.we    = w_we;
    assign s.adr   = w_adr;
    assign s.dat_w = w_dat;
    assign s.sel   = w_sel;

    assign m0.ack   = w_own0 & w_ack;
    assign m1.ack   = w_own1 & w_ack;
    assign m0.err   = w_own0 & w_timeout;
    assign m1.err   = w_own1 & w_timeout;
    assign m0.dat_r = w_own0 ? s.dat_r : '0;
    assign m1.dat_r = w_own1 ? s.dat_r : '0;

    assign gnt_o = {w_own1, w_own0};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
`ifdef WB_ARBITER_TIMEOUT_EN
            r_tcnt  <= 8'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0.cyc && m1.cyc) begin
                        r_state <= r_last ? OWN0 : OWN1;
                    end else if (m0.cyc) begin
                        r_state <= OWN0;
                    end else if (m1.cyc) begin
                        r_state <= OWN1;
                    end
                end
                OWN0: begin
                    if (!m0.cyc) begin
                        r_state <= IDLE;
                        r_last  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1.cyc) begin
                        r_state <= IDLE;
                        r_last  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef WB_ARBITER_TIMEOUT_EN
            if (!w_own || !w_cyc || !w_stb_req || s.ack || w_timeout) begin
                r_tcnt <= 8'd0;
            end else begin
                r_tcnt <= r_tcnt + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 2;
    localparam int TO    = 16;
    localparam int VW    = 2 + 3 + SEL_W + ADR_W + DAT_W + 4 + 2 * DAT_W;
`ifdef WB_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [ADR_W-1:0] m_adr [2];
    logic [DAT_W-1:0] m_dat [2];
    logic [SEL_W-1:0] m_sel [2];
    logic             m_we  [2];
    logic             m_cyc [2];
    logic             m_stb [2];
    logic [DAT_W-1:0] s_dat;
    logic             s_ack;
    logic [1:0]       gnt;

    int checks = 0;
    int errors = 0;

    wb_arbiter_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) m0_if ();
    wb_arbiter_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) m1_if ();
    wb_arbiter_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) s_if ();

    assign m0_if.adr = m_adr[0];
    assign m0_if.dat_w = m_dat[0];
    assign m0_if.sel = m_sel[0];
    assign m0_if.we  = m_we[0];
    assign m0_if.cyc = m_cyc[0];
    assign m0_if.stb = m_stb[0];
    assign m1_if.adr = m_adr[1];
    assign m1_if.dat_w = m_dat[1];
    assign m1_if.sel = m_sel[1];
    assign m1_if.we  = m_we[1];
    assign m1_if.cyc = m_cyc[1];
    assign m1_if.stb = m_stb[1];
    assign s_if.dat_r = s_dat;
    assign s_if.ack   = s_ack;
    assign s_if.err   = 1'b0;

    wb_arbiter #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .TIMEOUT(TO)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .gnt_o (gnt)
    );

    // Reference model: who owns the bus (-1 = nobody), who owned it last,
    // and how many consecutive cycles the owner's strobe has gone unanswered.
    int mown   = -1;
    bit mlast  = 1'b1;
    int mstall = 0;

    function automatic bit e_err();
        if (!TO_EN || mown < 0) return 1'b0;
        return m_stb[mown] && !s_ack && (mstall == TO - 1);
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mown   = -1;
            mlast  = 1'b1;
            mstall = 0;
        end else begin
            if (mown >= 0 && m_stb[mown] && !s_ack && !e_err()) mstall = mstall + 1;
            else mstall = 0;
            if (mown < 0) begin
                if (m_cyc[0] && m_cyc[1]) mown = mlast ? 0 : 1;
                else if (m_cyc[0]) mown = 0;
                else if (m_cyc[1]) mown = 1;
            end else if (!m_cyc[mown]) begin
                mlast = (mown == 1);
                mown  = -1;
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic [1:0]       g;
        logic             c, st, w, a0, e0, a1, e1;
        logic [SEL_W-1:0] se;
        logic [ADR_W-1:0] a;
        logic [DAT_W-1:0] d, d0, d1;
        bit               er;
        g = 2'b00; c = 1'b0; st = 1'b0; w = 1'b0; se = '0; a = '0; d = '0;
        a0 = 1'b0; e0 = 1'b0; a1 = 1'b0; e1 = 1'b0; d0 = '0; d1 = '0;
        er = e_err();
        if (mown >= 0) begin
            g  = (mown == 0) ? 2'b01 : 2'b10;
            c  = m_cyc[mown];
            st = m_stb[mown] && !er;
            w  = m_we[mown];
            se = m_sel[mown];
            a  = m_adr[mown];
            d  = m_dat[mown];
            if (mown == 0) begin
                a0 = s_ack && st; e0 = er; d0 = s_dat;
            end else begin
                a1 = s_ack && st; e1 = er; d1 = s_dat;
            end
        end
        return {g, c, st, w, se, a, d, a0, e0, a1, e1, d0, d1};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {gnt, s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.adr, s_if.dat_w,
                m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, m0_if.dat_r, m1_if.dat_r};
    endfunction

    function automatic bit model_ack(int x);
        return (mown == x) && m_stb[x] && s_ack && !e_err();
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
            m_we[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end
        s_ack = 1'b0;
        s_dat = '0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_i = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_1234;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; s_ack = 1'b1; s_dat = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want all zero", obs_vec());
        end
        step();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt_held: got %b, want 00", gnt);
        end
        idle_inputs();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_single_read();
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        m_adr[0] = 32'h0000_1004; m_sel[0] = 2'b11;
        #1;
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL read_pre_gnt: got %b, want 00", gnt);
        end
        step(); #1;
        checks++;
        if (gnt !== 2'b01 || s_if.adr !== 32'h0000_1004 || s_if.stb !== 1'b1) begin
            errors++;
            $display("FAIL read_grant: gnt=%b adr=%h stb=%b, want 01 00001004 1", gnt, s_if.adr, s_if.stb);
        end
        step();
        s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (m0_if.dat_r !== 32'hDEAD_BEEF || m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL read_data: dat=%h ack0=%b ack1=%b, want deadbeef 1 0",
                     m0_if.dat_r, m0_if.ack, m1_if.ack);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL read_vector: got %h, want %h", obs_vec(), exp_vec());
        end
        step();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
        step();
    endtask

    task automatic test_tie();
        logic [1:0] want [4];
        want = '{2'b01, 2'b01, 2'b00, 2'b10};
        do_reset();
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) m_cyc[0] = 1'b0;
            #1;
            checks++;
            if (gnt !== want[k]) begin
                errors++;
                $display("FAIL tie_seq[%0d]: got %b, want %b", k, gnt, want[k]);
            end
            step();
        end
        m_cyc[1] = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        bit         acked [2];
        logic [1:0] prev_g, last_run;
        int         runs;
        acked = '{1'b0, 1'b0};
        prev_g = 2'b00; last_run = 2'b00; runs = 0;
        do_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            for (int x = 0; x < 2; x++) begin
                m_cyc[x] = !acked[x];
                m_stb[x] = m_cyc[x];
                m_adr[x] = $urandom;
                m_dat[x] = $urandom;
                m_we[x]  = 1'($urandom_range(0, 1));
            end
            s_ack = 1'b1;
            s_dat = $urandom;
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr_vector[%0d]: got %h, want %h", cyc, obs_vec(), exp_vec());
            end
            if (gnt !== 2'b00 && prev_g === 2'b00) begin
                checks++;
                if (gnt === last_run) begin
                    errors++;
                    $display("FAIL rr_repeat[%0d]: got grant %b twice in a row", cyc, gnt);
                end
                last_run = gnt;
                runs++;
            end
            prev_g = gnt;
            for (int x = 0; x < 2; x++) acked[x] = model_ack(x);
            step();
        end
        checks++;
        if (runs < 8) begin
            errors++;
            $display("FAIL rr_runs: got %0d grants, want at least 8", runs);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_burst();
        int acks0, acks1;
        acks0 = 0; acks1 = 0;
        do_reset();
        m_cyc[1] = 1'b1;
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0100;
        s_ack = 1'b1;
        for (int b = 0; b < 8; b++) begin
            m_stb[1] = (b % 2 == 0);
            m_adr[1] = 32'h0000_8000 + 32'(b / 2) * 4;
            s_dat = $urandom;
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst_vector[%0d]: got %h, want %h", b, obs_vec(), exp_vec());
            end
            acks0 += int'(m0_if.ack);
            acks1 += int'(m1_if.ack);
            step();
        end
        checks++;
        if (acks1 !== 4 || acks0 !== 0) begin
            errors++;
            $display("FAIL burst_acks: m1=%0d m0=%0d, want 4 0", acks1, acks0);
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b10 || s_if.cyc !== 1'b0) begin
            errors++;
            $display("FAIL burst_drop: gnt=%b cyc=%b, want 10 0", gnt, s_if.cyc);
        end
        step(); #1;
        checks++;
        if (gnt !== 2'b00 || m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL burst_gap: gnt=%b ack0=%b ack1=%b, want 00 0 0", gnt, m0_if.ack, m1_if.ack);
        end
        step(); #1;
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL burst_handover: got %b, want 01", gnt);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        int n;
        bit want_err;
        n = TO_EN ? 20 : 100;
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 32'h0000_2000; m_dat[0] = 32'h1234_5678; m_sel[0] = 2'b01;
        step();
        for (int k = 1; k <= n; k++) begin
            want_err = TO_EN && (k == TO);
            #1;
            checks++;
            if (m0_if.err !== want_err || s_if.stb !== !want_err || m0_if.ack !== 1'b0) begin
                errors++;
                $display("FAIL timeout_stall[%0d]: err=%b stb=%b ack=%b, want %b %b 0",
                         k, m0_if.err, s_if.stb, m0_if.ack, want_err, !want_err);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_vector[%0d]: got %h, want %h", k, obs_vec(), exp_vec());
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_4000;
        s_ack = 1'b0;
        step(); #1;
        checks++;
        if (gnt !== 2'b10 || s_if.cyc !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: gnt=%b cyc=%b, want 10 1", gnt, s_if.cyc);
        end
        s_ack = 1'b1;
        #3 rst_i = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b00 || s_if.cyc !== 1'b0 || s_if.stb !== 1'b0 || m1_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: gnt=%b cyc=%b stb=%b ack=%b, want 00 0 0 0",
                     gnt, s_if.cyc, s_if.stb, m1_if.ack);
        end
        #1 rst_i = 1'b0;
        s_ack = 1'b0;
        step(); #1;
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL areset_regrant: got %b, want 10", gnt);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int x = 0; x < 2; x++) begin
                m_cyc[x] = ($urandom_range(0, 3) != 0);
                m_stb[x] = 1'($urandom_range(0, 1));
                m_we[x]  = 1'($urandom_range(0, 1));
                m_adr[x] = $urandom;
                m_dat[x] = $urandom;
                m_sel[x] = 2'($urandom_range(0, 3));
            end
            s_ack = ($urandom_range(0, 3) == 0);
            s_dat = $urandom;
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_vector[%0d]: got %h, want %h", cyc, obs_vec(), exp_vec());
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_round_robin();
        test_burst();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter. It sits between the moxie core (master 0) and a second bus master (master 1, e.g. DMA or debug port) on one side, and the wb_intercon master port on the other.
- Shares the single slave bus using round-robin arbitration.
- A granted master keeps ownership for as long as it holds cyc.
- Optionally terminates stalled cycles with an error response.

Parameters:
- ADR_W, 32, address width
- DAT_W, 32, data width
- SEL_W, 2, byte-select width
- TIMEOUT, 16, stall cycles before err is issued (timeout build only; valid range 2..255)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- m0_adr_i  in  ADR_W  master 0 address
- m0_dat_i  in  DAT_W  master 0 write data
- m0_dat_o  out  DAT_W  master 0 read data
- m0_sel_i  in  SEL_W  master 0 byte selects
- m0_we_i  in  1  master 0 write enable
- m0_cyc_i  in  1  master 0 cycle
- m0_stb_i  in  1  master 0 strobe
- m0_ack_o  out  1  master 0 acknowledge
- m0_err_o  out  1  master 0 error
- m1_*  (same nine signals as m0_*, same directions and widths)  master 1
- s_adr_o  out  ADR_W  to intercon: address
- s_dat_o  out  DAT_W  to intercon: write data
- s_dat_i  in  DAT_W  from intercon: read data
- s_sel_o  out  SEL_W  to intercon: byte selects
- s_we_o  out  1  to intercon: write enable
- s_cyc_o  out  1  to intercon: cycle
- s_stb_o  out  1  to intercon: strobe
- s_ack_i  in  1  from intercon: acknowledge
- gnt_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle

Behaviour:
- One clock (clk_i). Reset rst_i is asynchronous, active-high.
- State machine states: IDLE, OWN0, OWN1. Registers: state, last (last owner, 1 bit), tcnt (8 bits, timeout build only).
- Reset values:
  - state = IDLE, last = 1 (so m0 wins the first tie), tcnt = 0.
  - All outputs 0: gnt_o = 00, s_cyc_o = s_stb_o = s_we_o = 0, s_adr_o / s_dat_o / s_sel_o = 0, m*_ack_o = m*_err_o = 0, m*_dat_o = 0.
- IDLE transitions:
  - Only m0_cyc_i high -> OWN0. Only m1_cyc_i high -> OWN1.
  - Both high -> OWNx where x = !last (round robin).
  - Neither high -> stay in IDLE.
- OWNx transitions:
  - Stay while mx_cyc_i = 1.
  - When mx_cyc_i = 0 -> IDLE and last <= x.
  - There is exactly one dead cycle between owners. The other master's cyc is ignored while ownership is held.
- Latency: grant is registered. A master's first cycle with cyc=1 while IDLE reaches the slave on the following clock.
- Datapath in OWNx (combinational from state):
  - s_adr/dat/sel/we/stb/cyc_o = mx_*, with s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i.
  - mx_dat_o = s_dat_i and mx_ack_o = s_ack_i.
  - The non-owner receives ack = 0, err = 0, dat_o = 0.
- Datapath in IDLE: all s_* outputs 0, all acks 0.
- Owner dropping cyc mid-burst: the slave sees cyc fall on the same cycle. A late s_ack_i arriving in IDLE is discarded.
- Reset asserted mid-transfer: outputs go to their reset values immediately (asynchronously). The cycle is abandoned and no ack or err is produced.
- s_ack_i while s_stb_o = 0: ignored and not forwarded.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - tcnt increments each cycle in OWNx with s_stb_o=1 and s_ack_i=0.
  - tcnt clears on s_ack_i, on stb low, and on leaving OWNx.
  - When tcnt = TIMEOUT-1 and no ack arrives, the owner gets mx_err_o = 1 for exactly one cycle and tcnt clears.
  - s_stb_o is forced 0 in that same cycle. Ownership is retained until the master drops cyc.
  - The arbiter never asserts err and ack together; an ack arriving in the err cycle is suppressed.
- Without the macro: no tcnt, m*_err_o tied 0, and a stalled slave hangs the owner indefinitely.

Test Plan:
- m0 read of 0x00001004, slave acks 1 cycle after stb with 0xDEADBEEF -> gnt_o=01 one cycle after m0_cyc_i, s_adr_o=0x00001004, m0_dat_o=0xDEADBEEF with m0_ack_o=1, m1_ack_o=0.
- m0 and m1 raise cyc on the same edge after reset -> m0 granted first (gnt_o=01). After m0 drops cyc: one IDLE cycle (gnt_o=00), then gnt_o=10.
- Both masters hold cyc continuously with 1-beat transfers -> grants alternate 01,00,10,00,01...; no master is granted twice in a row.
- m1 owns and performs a 4-beat burst (cyc held, stb toggled) while m0 requests -> all 4 acks go to m1, m0_ack_o stays 0, m0 granted only after m1_cyc_i falls.
- Timeout build, TIMEOUT=16, slave never acks m0 write -> m0_err_o=1 exactly on the 16th stall cycle, s_stb_o=0 that cycle, no ack. Non-timeout build: no err after 100 cycles.
- rst_i pulsed (not clock-aligned) during an m1 transfer -> s_cyc_o, s_stb_o and gnt_o go to 0 before the next clock edge. After release with only m1 requesting, m1 is granted.
